// File: rtl/rast_pkg.sv
// Shared rasteriser types: iterator state, subsample step codes and step decoding.
package rast_pkg;

  typedef enum logic {WAIT, TEST} iter_state_t;

  localparam logic [3:0] SS_1X = 4'b1000;
  localparam logic [3:0] SS_2X = 4'b0100;
  localparam logic [3:0] SS_4X = 4'b0010;
  localparam logic [3:0] SS_8X = 4'b0001;

  // Codes that are not one-hot fall back to a full-pixel step.
  function automatic logic [31:0] step_from_code(input logic [3:0] code, input int unsigned radix);
    logic [31:0] one;
    one = 32'd1;
    case (code)
      SS_1X:   step_from_code = one << radix;
      SS_2X:   step_from_code = one << (radix - 1);
      SS_4X:   step_from_code = one << (radix - 2);
      SS_8X:   step_from_code = one << (radix - 3);
      default: step_from_code = one << radix;
    endcase
  endfunction

endpackage

// File: rtl/sample_iter_step.sv
// Combinational advance of the sample cursor by one group within the bounding box.
module sample_iter_step #(
  parameter int unsigned W     = 25,
  parameter int unsigned SAMPS = 4
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] llx_i,
  input  logic signed [W-1:0] urx_i,
  input  logic signed [W-1:0] ury_i,
  input  logic signed [W-1:0] step_i,
  output logic signed [W-1:0] next_x_o,
  output logic signed [W-1:0] next_y_o,
  output logic                row_end_o,
  output logic                last_o
);

  logic signed [W-1:0] grp_x;
  logic signed [W-1:0] row_y;

  always_comb begin
    grp_x     = x_i + $signed(W'(SAMPS)) * step_i;
    row_y     = y_i + step_i;
    row_end_o = grp_x > urx_i;
    last_o    = row_end_o && (row_y > ury_i);
    next_x_o  = row_end_o ? llx_i : grp_x;
    next_y_o  = row_end_o ? row_y : y_i;
  end

endmodule

// File: rtl/sample_iterator.sv
// Walks each triangle's bounding box emitting SAMPS adjacent samples per cycle.
// Optional perf counters (triCnt_U, sampCnt_U) enabled by SAMPLE_ITER_PERF_CNT_EN.
module sample_iterator
  import rast_pkg::*;
#(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned SAMPS  = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]             color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]               box_R13S,
  input  logic                                      validTri_R13H,
  input  logic [3:0]                                subSample_RnnnnU,
  output logic                                      halt_R13H,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]             color_R14U,
  output logic [1:0][SAMPS-1:0][SIGFIG-1:0]         sample_R14S,
  output logic [SAMPS-1:0]                          validSamp_R14H
`ifdef SAMPLE_ITER_PERF_CNT_EN
  ,
  output logic [31:0]                               triCnt_U,
  output logic [31:0]                               sampCnt_U
`endif
);

  localparam int unsigned W = SIGFIG + 1;

  iter_state_t state_q, state_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
  logic signed [W-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
  logic signed [W-1:0] step_q, step_d, x_q, x_d, y_q, y_d;
  logic signed [W-1:0] in_llx, in_lly, in_urx, in_ury, it_next_x, it_next_y, sx;
  logic                row_end, last, accept, in_ok;
  logic [1:0][SAMPS-1:0][SIGFIG-1:0] samp_d;
  logic [SAMPS-1:0]                  valid_d;

  sample_iter_step #(.W(W), .SAMPS(SAMPS)) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .llx_i    (llx_q),
    .urx_i    (urx_q),
    .ury_i    (ury_q),
    .step_i   (step_q),
    .next_x_o (it_next_x),
    .next_y_o (it_next_y),
    .row_end_o(row_end),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    llx_d   = llx_q;
    urx_d   = urx_q;
    ury_d   = ury_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;

    in_llx = W'($signed(box_R13S[0][0]));
    in_lly = W'($signed(box_R13S[0][1]));
    in_urx = W'($signed(box_R13S[1][0]));
    in_ury = W'($signed(box_R13S[1][1]));
    in_ok  = (in_urx >= in_llx) && (in_ury >= in_lly);

    // Halt drops during the last group, so a waiting triangle is taken on that same edge.
    halt_R13H = (state_q == TEST) && !last;
    accept    = validTri_R13H && in_ok && !halt_R13H;

    if (state_q == TEST) begin
      x_d = it_next_x;
      if (row_end) y_d = it_next_y;
      if (last) state_d = WAIT;
    end

    if (accept) begin
      state_d = TEST;
      tri_d   = tri_R13S;
      color_d = color_R13U;
      llx_d   = in_llx;
      urx_d   = in_urx;
      ury_d   = in_ury;
      step_d  = $signed(W'(step_from_code(subSample_RnnnnU, RADIX)));
      x_d     = in_llx;
      y_d     = in_lly;
    end
  end

  always_comb begin
    samp_d  = '0;
    valid_d = '0;
    sx      = '0;
    for (int unsigned s = 0; s < SAMPS; s++) begin
      sx           = x_q + $signed(W'(s)) * step_q;
      samp_d[0][s] = sx[SIGFIG-1:0];
      samp_d[1][s] = y_q[SIGFIG-1:0];
      valid_d[s]   = sx <= urx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= WAIT;
      tri_q          <= '0;
      color_q        <= '0;
      llx_q          <= '0;
      urx_q          <= '0;
      ury_q          <= '0;
      step_q         <= '0;
      x_q            <= '0;
      y_q            <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      llx_q   <= llx_d;
      urx_q   <= urx_d;
      ury_q   <= ury_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (state_q == TEST) begin
        tri_R14S       <= tri_q;
        color_R14U     <= color_q;
        sample_R14S    <= samp_d;
        validSamp_R14H <= valid_d;
      end else begin
        validSamp_R14H <= '0;
      end
    end
  end

`ifdef SAMPLE_ITER_PERF_CNT_EN
  logic [31:0] tri_cnt_q, samp_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_cnt_q  <= '0;
      samp_cnt_q <= '0;
    end else begin
      tri_cnt_q  <= tri_cnt_q + 32'(accept);
      samp_cnt_q <= samp_cnt_q + 32'($countones(validSamp_R14H));
    end
  end

  assign triCnt_U  = tri_cnt_q;
  assign sampCnt_U = samp_cnt_q;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator with hand-computed group sequences.
module tb_sample_iterator;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned SAMPS  = 4;
  localparam int PX = 1024;
  localparam logic [215:0] TA = {3{72'h111111_222222_333333}};
  localparam logic [215:0] TB = {3{72'h444444_555555_666666}};
  localparam logic [215:0] TC = {3{72'h777777_888888_999999}};

  logic clk, rst;
  logic [2:0][2:0][SIGFIG-1:0]      tri_i;
  logic [2:0][SIGFIG-1:0]           color_i;
  logic [1:0][1:0][SIGFIG-1:0]      box_i;
  logic                             valid_tri;
  logic [3:0]                       ss;
  logic                             halt;
  logic [2:0][2:0][SIGFIG-1:0]      tri_o;
  logic [2:0][SIGFIG-1:0]           color_o;
  logic [1:0][SAMPS-1:0][SIGFIG-1:0] samp;
  logic [SAMPS-1:0]                 vsamp;

  int total = 0;
  int bad   = 0;

  sample_iterator #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3), .SAMPS(SAMPS)) dut (
    .clk             (clk),
    .rst             (rst),
    .tri_R13S        (tri_i),
    .color_R13U      (color_i),
    .box_R13S        (box_i),
    .validTri_R13H   (valid_tri),
    .subSample_RnnnnU(ss),
    .halt_R13H       (halt),
    .tri_R14S        (tri_o),
    .color_R14U      (color_o),
    .sample_R14S     (samp),
    .validSamp_R14H  (vsamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic grp(input string tag, input logic [3:0] ev, input int ex, input int ey, input int estep);
    check({tag, "_valid"}, 256'(vsamp), 256'(ev));
    check({tag, "_x0"}, 256'(samp[0][0]), 256'(24'(ex)));
    check({tag, "_x3"}, 256'(samp[0][3]), 256'(24'(ex + 3 * estep)));
    check({tag, "_y"}, 256'(samp[1][2]), 256'(24'(ey)));
  endtask

  task automatic set_tri(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] code, input logic [215:0] t);
    box_i[0][0] = 24'(llx);
    box_i[0][1] = 24'(lly);
    box_i[1][0] = 24'(urx);
    box_i[1][1] = 24'(ury);
    tri_i       = t;
    color_i     = t[71:0];
    ss          = code;
    valid_tri   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid_tri = 1'b0; box_i = '0; tri_i = '0; color_i = '0; ss = 4'b1000;
    #12;
    check("rst_halt", 256'(halt), 256'(0));
    check("rst_valid", 256'(vsamp), 256'(0));
    check("rst_samp", 256'(samp), 256'(0));
    check("rst_tri", 256'(tri_o), 256'(0));
    rst = 1'b1;

    // 1: 8x2 px box, four full groups, halt high three cycles
    set_tri(0, 0, 7*PX, PX, 4'b1000, TA);
    check("t1_halt_wait", 256'(halt), 256'(0));
    tick;
    check("t1_halt_a", 256'(halt), 256'(1));
    check("t1_valid_lat", 256'(vsamp), 256'(0));
    valid_tri = 1'b0;
    tick; grp("t1_g0", 4'b1111, 0, 0, PX);
    check("t1_halt_b", 256'(halt), 256'(1));
    check("t1_tri", 256'(tri_o), 256'(TA));
    check("t1_color", 256'(color_o), 256'(TA[71:0]));
    tick; grp("t1_g1", 4'b1111, 4*PX, 0, PX);
    check("t1_halt_c", 256'(halt), 256'(1));
    tick; grp("t1_g2", 4'b1111, 0, PX, PX);
    check("t1_halt_d", 256'(halt), 256'(0));
    tick; grp("t1_g3", 4'b1111, 4*PX, PX, PX);
    tick;
    check("t1_idle_valid", 256'(vsamp), 256'(0));
    check("t1_idle_hold", 256'(samp[0][0]), 256'(24'(4*PX)));

    // 2: 5 px wide, offset box; second group of each row has only sample 0
    set_tri(2*PX, 5*PX, 6*PX, 6*PX, 4'b1000, TB);
    tick; valid_tri = 1'b0;
    tick; grp("t2_g0", 4'b1111, 2*PX, 5*PX, PX);
    tick; grp("t2_g1", 4'b0001, 6*PX, 5*PX, PX);
    tick; grp("t2_g2", 4'b1111, 2*PX, 6*PX, PX);
    check("t2_halt_last", 256'(halt), 256'(0));
    tick; grp("t2_g3", 4'b0001, 6*PX, 6*PX, PX);
    tick;
    check("t2_idle_valid", 256'(vsamp), 256'(0));

    // 2b: quarter-pixel step across one pixel
    set_tri(0, 0, PX, 0, 4'b0010, TC);
    tick; valid_tri = 1'b0;
    tick; grp("t2b_g0", 4'b1111, 0, 0, 256);
    check("t2b_halt", 256'(halt), 256'(0));
    tick; grp("t2b_g1", 4'b0001, PX, 0, 256);
    tick;
    check("t2b_idle_valid", 256'(vsamp), 256'(0));

    // 3: single-point box
    set_tri(3*PX, 3*PX, 3*PX, 3*PX, 4'b1000, TA);
    tick;
    check("t3_halt_a", 256'(halt), 256'(0));
    valid_tri = 1'b0;
    tick; grp("t3_g0", 4'b0001, 3*PX, 3*PX, PX);
    check("t3_halt_b", 256'(halt), 256'(0));
    tick;
    check("t3_idle_valid", 256'(vsamp), 256'(0));

    // 4: degenerate box dropped, next triangle accepted immediately after
    set_tri(5*PX, 0, 2*PX, 0, 4'b1000, TC);
    tick;
    check("t4_halt_deg", 256'(halt), 256'(0));
    set_tri(PX, 2*PX, PX, 2*PX, 4'b1000, TB);
    tick;
    check("t4_valid_deg", 256'(vsamp), 256'(0));
    valid_tri = 1'b0;
    tick; grp("t4_g0", 4'b0001, PX, 2*PX, PX);
    check("t4_tri", 256'(tri_o), 256'(TB));
    tick;
    check("t4_idle_valid", 256'(vsamp), 256'(0));

    // 5: back-to-back, second triangle taken on the first's last group
    set_tri(0, 0, 7*PX, 0, 4'b1000, TA);
    tick;
    check("t5_halt_a", 256'(halt), 256'(1));
    set_tri(10*PX, 0, 15*PX, 0, 4'b1000, TB);
    tick; grp("t5_a0", 4'b1111, 0, 0, PX);
    check("t5_halt_last", 256'(halt), 256'(0));
    tick; grp("t5_a1", 4'b1111, 4*PX, 0, PX);
    check("t5_tri_a", 256'(tri_o), 256'(TA));
    check("t5_halt_b", 256'(halt), 256'(1));
    valid_tri = 1'b0;
    tick; grp("t5_b0", 4'b1111, 10*PX, 0, PX);
    check("t5_tri_b", 256'(tri_o), 256'(TB));
    check("t5_halt_c", 256'(halt), 256'(0));
    tick; grp("t5_b1", 4'b0011, 14*PX, 0, PX);
    tick;
    check("t5_idle_valid", 256'(vsamp), 256'(0));

    // 6: async reset mid-triangle, then a fresh triangle
    set_tri(0, 0, 7*PX, PX, 4'b1000, TA);
    tick; valid_tri = 1'b0;
    tick; grp("t6_g0", 4'b1111, 0, 0, PX);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", 256'(vsamp), 256'(0));
    check("t6_rst_halt", 256'(halt), 256'(0));
    check("t6_rst_samp", 256'(samp), 256'(0));
    check("t6_rst_tri", 256'(tri_o), 256'(0));
    #2 rst = 1'b1;
    set_tri(20*PX, 4*PX, 20*PX, 4*PX, 4'b1000, TC);
    tick; valid_tri = 1'b0;
    tick; grp("t6_g1", 4'b0001, 20*PX, 4*PX, PX);
    check("t6_tri", 256'(tri_o), 256'(TC));
    tick;
    check("t6_idle_valid", 256'(vsamp), 256'(0));
    check("t6_idle_halt", 256'(halt), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
